param_window_loader: RTL and testbench
======================================

PARAM_WINDOW_LOADER -- requirements
Module: param_window_loader

Interface
REQ-001 Parameter DATA_W, default 8: width of memory word, weight and feature.
REQ-002 Parameter ADDR_W, default 6: memory address width.
REQ-003 Parameter K, default 3: kernel edge; K*K taps per channel, K >= 1.
REQ-004 Parameter IMG_W, default 4: feature-map row pitch in words.
REQ-005 Parameter NUM_CH, default 1: channels per window job, NUM_CH >= 1.
REQ-006 Parameter CH_STRIDE, default 16: feature address step between channels.
REQ-007 Parameter W_BASE, default 0: weight region base address.
REQ-008 clk  in  1  single clock; all state on rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-010 start  in  1  job request; accepted only in IDLE.
REQ-011 feature_baseaddr  in  ADDR_W  window top-left address; sampled at acceptance.
REQ-012 q  in  DATA_W  memory read data, valid one cycle after addr/rd_en.
REQ-013 addr  out  ADDR_W  memory read address.
REQ-014 rd_en  out  1  memory read strobe.
REQ-015 busy  out  1  job in progress.
REQ-016 w_out  out  DATA_W  weight of current tap pair.
REQ-017 f_out  out  DATA_W  feature of current tap pair.
REQ-018 acc_en  out  1  w_out/f_out pair valid this cycle.
REQ-019 rst_pe  out  1  PE accumulator clear.
REQ-020 is_done_o  out  1  one-cycle job-complete pulse.

Function
REQ-021 States IDLE, FETCH_W, FETCH_F, DRAIN, DONE; IDLE->FETCH_W on start, FETCH_W->FETCH_F always, FETCH_F->FETCH_W if taps remain else DRAIN, DRAIN->DONE, DONE->IDLE.
REQ-022 Tap index n = c*K*K + t, c in 0..NUM_CH-1, t in 0..K*K-1, r = t/K, col = t%K; N = NUM_CH*K*K total taps, issued in increasing n.
REQ-023 FETCH_W: addr = W_BASE + n, rd_en = 1.
REQ-024 FETCH_F: addr = base_q + c*CH_STRIDE + r*IMG_W + col, rd_en = 1; base_q is the sampled feature_baseaddr.
REQ-025 All address arithmetic modulo 2^ADDR_W; wrap-around silent, no error flag.
REQ-026 q in the cycle after FETCH_W is registered into the weight register; w_out drives that register.
REQ-027 Cycle after each FETCH_F: f_out = q, acc_en = 1; w_out holds the same tap's weight.
REQ-028 acc_en = 0 in all other cycles; f_out = 0 when acc_en = 0.
REQ-029 With start accepted in cycle 0: FETCH_W at cycles 2n+1, FETCH_F at 2n+2, acc_en at 2n+3, DRAIN at 2N+1, DONE at 2N+2.
REQ-030 busy = 1 in FETCH_W, FETCH_F, DRAIN, DONE; 0 in IDLE.
REQ-031 is_done_o = 1 only in DONE; rst_pe = 1 in DONE or while rst = 0.
REQ-032 start while busy = 1 (including DONE) ignored; feature_baseaddr changes after acceptance have no effect.
REQ-033 rd_en = 0 and addr = 0 in IDLE, DRAIN, DONE.
REQ-034 Back-to-back jobs: start in the IDLE cycle after DONE accepted with no extra gap.

Reset
REQ-035 rst = 0 asynchronously forces IDLE, clears tap counters, base_q and weight register.
REQ-036 During reset: addr, rd_en, busy, w_out, f_out, acc_en, is_done_o = 0; rst_pe = 1.
REQ-037 Reset mid-job abandons the job; no is_done_o; after release, IDLE awaits a new start.

Verification
REQ-038 Defaults, base 8, start in cycle 0 -> feature addrs 8,9,10,12,13,14,16,17,18 in cycles 2..18 (even); weight addrs 0..8 in odd cycles 1..17; acc_en at cycles 3,5,...,19; is_done_o and rst_pe at cycle 20; busy cycles 1..20.
REQ-039 Memory model mem[i] = i, base 8 -> pairs (w,f) = (0,8),(1,9),(2,10),(3,12),...,(8,18) on acc_en.
REQ-040 NUM_CH=2, CH_STRIDE=16, base 0 -> channel 1 feature addrs 16,17,18,20,21,22,24,25,26; weight addrs 9..17; done at cycle 38.
REQ-041 ADDR_W=6, base 60 -> feature addrs 60,61,62,0,1,2,4,5,6 (wrap); no stall.
REQ-042 start held high through DONE and beyond -> second job begins in IDLE cycle 21; start pulses during busy ignored.
REQ-043 rst = 0 at cycle 7 -> all outputs 0 and rst_pe = 1 immediately; no is_done_o; new start after release runs a full job from tap 0.

Source files
------------

// File: rtl/param_window_loader.sv
// Streams weight/feature tap pairs for a KxK (xNUM_CH) convolution window from a
// single synchronous-read memory, alternating weight and feature fetches.
module param_window_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned K         = 3,
    parameter int unsigned IMG_W     = 4,
    parameter int unsigned NUM_CH    = 1,
    parameter int unsigned CH_STRIDE = 16,
    parameter int unsigned W_BASE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] feature_baseaddr,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic              busy,
    output logic [DATA_W-1:0] w_out,
    output logic [DATA_W-1:0] f_out,
    output logic              acc_en,
    output logic              rst_pe,
    output logic              is_done_o
);

    localparam int unsigned N  = NUM_CH * K * K;
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, FETCH_W, FETCH_F, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              acc_en_q;
    logic              done_q;
    logic [DATA_W-1:0] w_q;
    logic [NW-1:0]     n_q, n_d;
    logic [CW-1:0]     c_q, c_d;
    logic [KW-1:0]     r_q, r_d;
    logic [KW-1:0]     col_q, col_d;
    logic              last_tap;
    logic [ADDR_W-1:0] feat_addr;
    logic [ADDR_W-1:0] w_addr_next;

    always_comb begin
        last_tap = (n_q == NW'(N - 1));
        n_d      = n_q + 1'b1;
        col_d    = col_q + 1'b1;
        r_d      = r_q;
        c_d      = c_q;
        // Column wraps into row, row wraps into channel.
        if (col_q == KW'(K - 1)) begin
            col_d = '0;
            if (r_q == KW'(K - 1)) begin
                r_d = '0;
                c_d = c_q + 1'b1;
            end else begin
                r_d = r_q + 1'b1;
            end
        end
        feat_addr   = ADDR_W'(32'(base_q) + 32'(c_q) * CH_STRIDE
                              + 32'(r_q) * IMG_W + 32'(col_q));
        w_addr_next = ADDR_W'(W_BASE + 32'(n_d));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            acc_en_q <= 1'b0;
            done_q   <= 1'b0;
            w_q      <= '0;
            n_q      <= '0;
            c_q      <= '0;
            r_q      <= '0;
            col_q    <= '0;
        end else begin
            acc_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH_W;
                        base_q  <= feature_baseaddr;
                        addr_q  <= ADDR_W'(W_BASE);
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        n_q     <= '0;
                        c_q     <= '0;
                        r_q     <= '0;
                        col_q   <= '0;
                    end
                end
                FETCH_W: begin
                    state_q <= FETCH_F;
                    addr_q  <= feat_addr;
                end
                FETCH_F: begin
                    // q now carries the weight requested in FETCH_W.
                    w_q      <= q;
                    acc_en_q <= 1'b1;
                    n_q      <= n_d;
                    c_q      <= c_d;
                    r_q      <= r_d;
                    col_q    <= col_d;
                    if (last_tap) begin
                        state_q <= DRAIN;
                        addr_q  <= '0;
                        rd_en_q <= 1'b0;
                    end else begin
                        state_q <= FETCH_W;
                        addr_q  <= w_addr_next;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr      = addr_q;
    assign rd_en     = rd_en_q;
    assign busy      = busy_q;
    assign w_out     = w_q;
    assign f_out     = acc_en_q ? q : '0;
    assign acc_en    = acc_en_q;
    assign is_done_o = done_q;
    assign rst_pe    = done_q | ~rst;

endmodule

// File: tb/tb_param_window_loader.sv
// Scoreboard bench for param_window_loader: stimulus pushes expected reads, tap pairs
// and busy/done windows; a negedge monitor pops and compares for two configurations.
module tb_param_window_loader;

    localparam int AW = 6;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start0, start1;
    logic [AW-1:0] fba;
    logic [DW-1:0] q0, q1;
    logic [AW-1:0] addr0, addr1;
    logic          rd_en0, rd_en1, busy0, busy1, acc_en0, acc_en1;
    logic          rst_pe0, rst_pe1, done0, done1;
    logic [DW-1:0] w0, w1, f0, f1;

    param_window_loader dut0 (
        .clk(clk), .rst(rst), .start(start0), .feature_baseaddr(fba), .q(q0),
        .addr(addr0), .rd_en(rd_en0), .busy(busy0), .w_out(w0), .f_out(f0),
        .acc_en(acc_en0), .rst_pe(rst_pe0), .is_done_o(done0)
    );

    param_window_loader #(.NUM_CH(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .feature_baseaddr(fba), .q(q1),
        .addr(addr1), .rd_en(rd_en1), .busy(busy1), .w_out(w1), .f_out(f1),
        .acc_en(acc_en1), .rst_pe(rst_pe1), .is_done_o(done1)
    );

    logic [DW-1:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    always @(posedge clk) begin
        q0 <= mem[addr0];
        q1 <= mem[addr1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t rdq[$];
    ev_t accq[$];
    bit  eb[2][0:1023];
    bit  ed[2][0:1023];
    int  checks = 0;
    int  passed = 0;

    int F8  [18] = '{8, 9, 10, 12, 13, 14, 16, 17, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int F60 [18] = '{60, 61, 62, 0, 1, 2, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int FC2 [18] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 16, 17, 18, 20, 21, 22, 24, 25, 26};

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    endfunction

    function automatic ev_t mk(int id, int c, int a, int b);
        ev_t e;
        e.id = id; e.cyc = c; e.a = a; e.b = b;
        return e;
    endfunction

    task automatic push_job(int id, int t0, int nch, int feat[18]);
        int nt = nch * 9;
        for (int n = 0; n < nt; n++) begin
            rdq.push_back(mk(id, t0 + 2*n + 1, n, 0));
            rdq.push_back(mk(id, t0 + 2*n + 2, feat[n], 0));
            accq.push_back(mk(id, t0 + 2*n + 3, n, feat[n]));
        end
        for (int c = t0 + 1; c <= t0 + 2*nt + 2; c++) eb[id][c] = 1'b1;
        ed[id][t0 + 2*nt + 2] = 1'b1;
    endtask

    task automatic mon(int id, logic rd, int ad, logic acc, int w, int f,
                       logic bsy, logic dn, logic pe);
        ev_t e;
        if (rd) begin
            if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rdq.pop_front();
                chk("rd_inst", id, e.id);
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_addr", ad, e.a);
            end
        end else chk("addr_idle", ad, 0);
        if (acc) begin
            if (accq.size() == 0) chk("acc_unexpected", 1, 0);
            else begin
                e = accq.pop_front();
                chk("acc_inst", id, e.id);
                chk("acc_cycle", cyc, e.cyc);
                chk("w_out", w, e.a);
                chk("f_out", f, e.b);
            end
        end else chk("f_out_idle", f, 0);
        chk("busy", int'(bsy), int'(eb[id][cyc]));
        chk("is_done", int'(dn), int'(ed[id][cyc]));
        chk("rst_pe", int'(pe), int'(ed[id][cyc] || !rst));
        if (!rst) chk("w_out_reset", w, 0);
    endtask

    always @(negedge clk) begin
        if (cyc < 1024) begin
            mon(0, rd_en0, int'(addr0), acc_en0, int'(w0), int'(f0), busy0, done0, rst_pe0);
            mon(1, rd_en1, int'(addr1), acc_en1, int'(w1), int'(f1), busy1, done1, rst_pe1);
        end
    end

    task automatic at(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; fba = '0;
        at(3);  rst = 1'b1;

        // base 8; later base changes and a start during busy must be ignored
        at(10); fba = 8; start0 = 1'b1; push_job(0, 10, 1, F8);
        at(11); start0 = 1'b0;
        at(12); fba = 40;
        at(15); fba = 33; start0 = 1'b1;
        at(16); start0 = 1'b0;

        at(40); fba = 0; start1 = 1'b1; push_job(1, 40, 2, FC2);
        at(41); start1 = 1'b0;

        at(90); fba = 60; start0 = 1'b1; push_job(0, 90, 1, F60);
        at(91); start0 = 1'b0;

        // start held high: second job accepted in the IDLE cycle after DONE
        at(120); fba = 8; start0 = 1'b1; push_job(0, 120, 1, F8); push_job(0, 141, 1, F8);
        at(150); start0 = 1'b0;

        // reset mid-job abandons everything still outstanding
        at(180); start0 = 1'b1; push_job(0, 180, 1, F8);
        at(181); start0 = 1'b0;
        at(187); rst = 1'b0;
        rdq.delete();
        accq.delete();
        for (int c = 187; c < 1024; c++) begin
            eb[0][c] = 1'b0;
            ed[0][c] = 1'b0;
        end
        at(190); rst = 1'b1;
        at(195); start0 = 1'b1; push_job(0, 195, 1, F8);
        at(196); start0 = 1'b0;

        at(225);
        chk("rdq_drained", rdq.size(), 0);
        chk("accq_drained", accq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
